// File: rtl/rgb_pkg.sv
// rgb_fader shared package: FSM states and colour packing.
// Channel offsets are common with the RGB PWM driver.
package rgb_pkg;

  typedef enum logic {
    IDLE,
    FADE
  } state_e;

  localparam int NBPC_DEF = 8;

  localparam int R_LSB = 2 * NBPC_DEF;
  localparam int G_LSB = NBPC_DEF;
  localparam int B_LSB = 0;

endpackage

// File: rtl/rgb_fader_channel.sv
// rgb_fader_channel: one colour channel register.
// Steps one LSB toward its target per tick; load/clear override.
module rgb_fader_channel #(
  parameter int NBPC = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            tick,
  input  logic            load,
  input  logic            clr,
  input  logic [NBPC-1:0] tgt,
  output logic [NBPC-1:0] cur,
  output logic            at_tgt
);

  logic [NBPC-1:0] cur_q, cur_d;

  // next value: clear, load target, or one step toward target
  always_comb begin
    cur_d = cur_q;
    if (clr) begin
      cur_d = '0;
    end else if (load) begin
      cur_d = tgt;
    end else if (tick) begin
      if (cur_q < tgt) begin
        cur_d = cur_q + 1'b1;
      end else if (cur_q > tgt) begin
        cur_d = cur_q - 1'b1;
      end
    end
  end

  // channel register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_q <= '0;
    end else begin
      cur_q <= cur_d;
    end
  end

  assign cur    = cur_q;
  assign at_tgt = (cur_q == tgt);

endmodule

// File: rtl/rgb_fader.sv
// rgb_fader: ramps a registered RGB colour toward accepted targets.
// Optional blink in IDLE when RGB_FADER_BLINK_EN is defined.
module rgb_fader #(
  parameter int NBPC        = rgb_pkg::NBPC_DEF,
  parameter int PRESCALE    = 1000,
  parameter int BLINK_TICKS = 250
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [3*NBPC-1:0] in_color,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [3*NBPC-1:0] out_color,
  output logic              busy,
  output logic              done
`ifdef RGB_FADER_BLINK_EN
  ,
  input  logic              blink
`endif
);

  import rgb_pkg::*;

  localparam int CW = 3 * NBPC;
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  if (PRESCALE < 1) begin : g_bad_prescale
    $error("PRESCALE must be >= 1");
  end
  if (BLINK_TICKS < 1) begin : g_bad_blink
    $error("BLINK_TICKS must be >= 1");
  end

  state_e          state_q, state_d;
  logic [CW-1:0]   target_q, target_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic            done_q, done_d;
  logic            tick, accept;
  logic            ch_step, ch_load, ch_clr;
  logic [2:0]      at_tgt;

  assign in_ready = en && (state_q == IDLE);
  assign accept   = in_valid && in_ready;
  assign tick     = (presc_q == PW'(PRESCALE - 1));
  assign busy     = (state_q == FADE);
  assign done     = done_q;

  // FSM next state, target latch, prescaler and step strobe
  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    presc_d  = presc_q;
    done_d   = 1'b0;
    ch_step  = 1'b0;
    if (en) begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            target_d = in_color;
            presc_d  = '0;
            state_d  = FADE;
          end
`ifdef RGB_FADER_BLINK_EN
          else if (!blink) begin
            presc_d = '0;
          end else begin
            presc_d = tick ? '0 : presc_q + 1'b1;
          end
`endif
        end
        FADE: begin
          if (&at_tgt) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            presc_d = tick ? '0 : presc_q + 1'b1;
            ch_step = tick;
          end
        end
      endcase
    end
  end

  // control registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      target_q <= '0;
      presc_q  <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      presc_q  <= presc_d;
      done_q   <= done_d;
    end
  end

`ifdef RGB_FADER_BLINK_EN
  localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

  logic [BW-1:0] bcnt_q, bcnt_d;
  logic          off_q, off_d;

  // blink phase: target phase first, toggled every BLINK_TICKS ticks
  always_comb begin
    bcnt_d  = bcnt_q;
    off_d   = off_q;
    ch_load = 1'b0;
    ch_clr  = 1'b0;
    if (en && (state_q == IDLE)) begin
      if (accept || !blink) begin
        bcnt_d  = '0;
        off_d   = 1'b0;
        ch_load = 1'b1;
      end else begin
        if (tick) begin
          if (bcnt_q == BW'(BLINK_TICKS - 1)) begin
            bcnt_d = '0;
            off_d  = ~off_q;
          end else begin
            bcnt_d = bcnt_q + 1'b1;
          end
        end
        ch_clr  = off_d;
        ch_load = !off_d;
      end
    end
  end

  // blink counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcnt_q <= '0;
      off_q  <= 1'b0;
    end else begin
      bcnt_q <= bcnt_d;
      off_q  <= off_d;
    end
  end
`else
  assign ch_load = 1'b0;
  assign ch_clr  = 1'b0;
`endif

  for (genvar i = 0; i < 3; i++) begin : g_ch
    rgb_fader_channel #(
      .NBPC(NBPC)
    ) u_ch (
      .clk   (clk),
      .rst_n (rst_n),
      .tick  (ch_step),
      .load  (ch_load),
      .clr   (ch_clr),
      .tgt   (target_q[i*NBPC +: NBPC]),
      .cur   (out_color[i*NBPC +: NBPC]),
      .at_tgt(at_tgt[i])
    );
  end

endmodule

// File: tb/tb_rgb_fader.sv
// tb_rgb_fader: directed fades checked against a distance/latency model.
// Blink phase checks are added when RGB_FADER_BLINK_EN is defined.
module tb_rgb_fader;

  localparam int NB = 8;
  localparam int P  = 4;

  logic        clk      = 1'b0;
  logic        rst_n    = 1'b0;
  logic        en       = 1'b1;
  logic        in_valid = 1'b0;
  logic [23:0] in_color = 24'h0;
  logic        in_ready, busy, done;
  logic [23:0] out_color;
`ifdef RGB_FADER_BLINK_EN
  logic        blink    = 1'b0;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  bit skip_out = 1'b0;

  rgb_fader #(
    .NBPC(NB),
    .PRESCALE(P),
    .BLINK_TICKS(2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .in_color (in_color),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_color(out_color),
    .busy     (busy),
    .done     (done)
`ifdef RGB_FADER_BLINK_EN
    ,
    .blink    (blink)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // model: colour is a function of start, target and enabled FADE cycles
  logic [23:0] m_start = 0, m_tgt = 0, m_cur = 0;
  bit          m_fade = 0, m_done = 0;
  int          m_n = 0, m_d = 0;

  function automatic int absd(input int a, input int b);
    return (a > b) ? a - b : b - a;
  endfunction

  function automatic logic [23:0] mcolor(input logic [23:0] s,
                                         input logic [23:0] t,
                                         input int n);
    logic [23:0] r;
    r = '0;
    for (int c = 0; c < 3; c++) begin
      int sv, tv, k;
      sv = int'(s[c*8 +: 8]);
      tv = int'(t[c*8 +: 8]);
      k  = n / P;
      if (k > absd(sv, tv)) k = absd(sv, tv);
      r[c*8 +: 8] = 8'((tv >= sv) ? sv + k : sv - k);
    end
    return r;
  endfunction

  function automatic int maxdist(input logic [23:0] s, input logic [23:0] t);
    int m;
    m = 0;
    for (int c = 0; c < 3; c++)
      if (absd(int'(s[c*8 +: 8]), int'(t[c*8 +: 8])) > m)
        m = absd(int'(s[c*8 +: 8]), int'(t[c*8 +: 8]));
    return m;
  endfunction

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_start = 0; m_tgt = 0; m_cur = 0;
        m_fade = 0; m_done = 0; m_n = 0; m_d = 0;
      end else begin
        m_done = 0;
        if (en) begin
          if (!m_fade) begin
            if (in_valid) begin
              m_start = m_cur;
              m_tgt   = in_color;
              m_n     = 0;
              m_d     = maxdist(m_cur, in_color);
              m_fade  = 1;
            end
          end else begin
            m_n++;
            if (m_n == m_d * P + 1) begin
              m_fade = 0;
              m_done = 1;
              m_cur  = m_tgt;
            end else begin
              m_cur = mcolor(m_start, m_tgt, m_n);
            end
          end
        end
      end
    end
  end

  // compare every cycle on the falling edge
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (!skip_out) chk("out_color", 32'(out_color), 32'(m_cur));
        chk("busy", 32'(busy), 32'(m_fade));
        chk("done", 32'(done), 32'(m_done));
        chk("in_ready", 32'(in_ready), 32'(en && !m_fade));
      end
    end
  end

  task automatic send(input logic [23:0] c);
    @(posedge clk); #2;
    in_color = c;
    in_valid = 1'b1;
    @(posedge clk); #3;
    in_valid = 1'b0;
  endtask

  // counts busy samples until done; optionally drops en for 10 cycles
  task automatic run(input int drop, output int nb, output int nd);
    int off;
    bit dropped;
    nb = 0; nd = 0; off = 0; dropped = 0;
    for (int i = 0; i < 3000; i++) begin
      if (busy) nb++;
      if (done) begin
        nd++;
        break;
      end
      if (!dropped && nb == drop) begin
        en = 1'b0;
        dropped = 1;
      end else if (!en) begin
        off++;
        if (off == 10) en = 1'b1;
      end
      @(posedge clk); #3;
    end
    if (nd == 0) begin
      n_tests++; n_fail++;
      $display("FAIL timeout: no done seen");
    end
  endtask

  int nb, nd;

  initial begin
    #12 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_out", 32'(out_color), 32'h0);
    chk("rst_ready", 32'(in_ready), 32'h1);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);

    send(24'h030001);
    run(-1, nb, nd);
    chk("up_busy_cycles", 32'(nb), 32'd13);
    @(posedge clk); #3;
    chk("up_final", 32'(out_color), 32'h030001);

    send(24'h050505);
    run(-1, nb, nd);
    chk("to555_busy_cycles", 32'(nb), 32'd21);

    send(24'h020802);
    run(-1, nb, nd);
    chk("down_busy_cycles", 32'(nb), 32'd13);
    @(posedge clk); #3;
    chk("down_final", 32'(out_color), 32'h020802);

    send(24'h020802);
    run(-1, nb, nd);
    chk("equal_busy_cycles", 32'(nb), 32'd1);
    chk("equal_color", 32'(out_color), 32'h020802);

    send(24'h050505);
    run(5, nb, nd);
    chk("en_drop_busy_cycles", 32'(nb), 32'd23);
    @(posedge clk); #3;
    chk("en_drop_final", 32'(out_color), 32'h050505);

`ifdef RGB_FADER_BLINK_EN
    begin
      logic [23:0] prev;
      int cnt, nchg, w;
      send(24'h0F0F0F);
      run(-1, nb, nd);
      @(posedge clk); #3;
      skip_out = 1'b1;
      blink = 1'b1;
      prev = out_color;
      cnt = 0; nchg = 0;
      for (int i = 0; i < 40; i++) begin
        @(posedge clk); #3;
        cnt++;
        if (out_color != prev) begin
          if (nchg >= 1) chk("blink_period", 32'(cnt), 32'd8);
          nchg++;
          cnt = 0;
          prev = out_color;
        end
      end
      chk("blink_toggles", 32'(nchg >= 4), 32'd1);
      w = 0;
      while (out_color != 24'h0 && w < 20) begin
        @(posedge clk); #3;
        w++;
      end
      chk("blink_off_phase", 32'(out_color), 32'h0);
      blink = 1'b0;
      @(posedge clk); #3;
      chk("blink_restore", 32'(out_color), 32'h0F0F0F);
      skip_out = 1'b0;
    end
`endif

    send(24'hFFFFFF);
    repeat (6) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midfade_rst_out", 32'(out_color), 32'h0);
    chk("midfade_rst_busy", 32'(busy), 32'h0);
    @(posedge clk); #2 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
